// File: rtl/mips_pkg.sv
// Shared fetch-side definitions for the MIPS pipeline front end.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_e;

    // Instruction addresses are word aligned; low two bits of any target are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with next-PC selection, stall/flush handling and a
// one-entry buffer that holds a redirect arriving while the front end is stalled.
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      instr_in,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic             pc_write,
    output logic [31:0]      next_pc,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc_plus4,
    output logic [31:0]      id_instr,
    output logic             id_valid,
    output logic [CNT_W-1:0] bubble_cnt
);

    fetch_state_e     state_r;
    fetch_state_e     next_state_s;
    logic [31:0]      pend_target_r;
    logic [31:0]      next_pend_s;
    logic [31:0]      redirect_aligned_s;
    logic [31:0]      pc_plus4_s;
    logic [31:0]      next_pc_s;
    logic             bubble_s;
    logic [31:0]      id_pc_r;
    logic [31:0]      id_pc_plus4_r;
    logic [31:0]      id_instr_r;
    logic             id_valid_r;
    logic [CNT_W-1:0] bubble_cnt_r;

    assign redirect_aligned_s = word_align(redirect_target);
    assign pc_plus4_s         = pc_in + PC_INC;

    // A bubble replaces IF/ID on flush, or when released from stall onto a redirect path.
    assign bubble_s = flush | (~stall & (redirect_valid | (state_r == PEND)));

    // Next-PC selection presented to the PC register this cycle.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (rst) begin
            next_pc_s = RESET_PC;
        end else if (redirect_valid) begin
            next_pc_s = redirect_aligned_s;
        end else if (state_r == PEND) begin
            next_pc_s = pend_target_r;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Pending-redirect FSM: newest redirect seen during a stall wins.
    always_comb begin
        next_state_s = state_r;
        next_pend_s  = pend_target_r;
        case (state_r)
            RUN: begin
                if (stall && redirect_valid) begin
                    next_state_s = PEND;
                    next_pend_s  = redirect_aligned_s;
                end else begin
                    next_state_s = RUN;
                end
            end
            PEND: begin
                if (!stall) begin
                    next_state_s = RUN;
                end else if (redirect_valid) begin
                    next_pend_s = redirect_aligned_s;
                end else begin
                    next_state_s = PEND;
                end
            end
            default: begin
                next_state_s = RUN;
                next_pend_s  = 32'h0000_0000;
            end
        endcase
    end

    // FSM, pending target, IF/ID register and bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RUN;
            pend_target_r <= 32'h0000_0000;
            id_pc_r       <= 32'h0000_0000;
            id_pc_plus4_r <= 32'h0000_0000;
            id_instr_r    <= NOP_INSTR;
            id_valid_r    <= 1'b0;
            bubble_cnt_r  <= '0;
        end else begin
            state_r       <= next_state_s;
            pend_target_r <= next_pend_s;
            if (bubble_s) begin
                id_pc_r       <= 32'h0000_0000;
                id_pc_plus4_r <= 32'h0000_0000;
                id_instr_r    <= NOP_INSTR;
                id_valid_r    <= 1'b0;
                if (!(&bubble_cnt_r)) begin
                    bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
                end
            end else if (!stall) begin
                id_pc_r       <= pc_in;
                id_pc_plus4_r <= pc_plus4_s;
                id_instr_r    <= instr_in;
                id_valid_r    <= 1'b1;
            end
        end
    end

    assign pc_write    = rst | ~stall;
    assign next_pc     = next_pc_s;
    assign id_pc       = id_pc_r;
    assign id_pc_plus4 = id_pc_plus4_r;
    assign id_instr    = id_instr_r;
    assign id_valid    = id_valid_r;
    assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver queues hand-computed expectations,
// the monitor pops one per cycle mid-cycle and compares against the DUT.
module tb_if_id_stage;

    localparam int TB_CNT_W = 3;

    typedef struct {
        string       name;
        logic        pcw;
        logic [31:0] npc;
        logic [31:0] idpc;
        logic [31:0] idpc4;
        logic [31:0] idins;
        logic        idv;
        int          cnt;
    } exp_t;

    logic                clk;
    logic                rst;
    logic [31:0]         pc_in;
    logic [31:0]         instr_in;
    logic                stall;
    logic                flush;
    logic                redirect_valid;
    logic [31:0]         redirect_target;
    logic                pc_write;
    logic [31:0]         next_pc;
    logic [31:0]         id_pc;
    logic [31:0]         id_pc_plus4;
    logic [31:0]         id_instr;
    logic                id_valid;
    logic [TB_CNT_W-1:0] bubble_cnt;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    if_id_stage #(.RESET_PC(32'h0000_3000), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .pc_write(pc_write), .next_pc(next_pc),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
        .id_valid(id_valid), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: mid-cycle, compare whatever expectation the driver queued for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "pc_write",    {31'd0, pc_write},   {31'd0, e.pcw});
            chk(e.name, "next_pc",     next_pc,             e.npc);
            chk(e.name, "id_pc",       id_pc,               e.idpc);
            chk(e.name, "id_pc_plus4", id_pc_plus4,         e.idpc4);
            chk(e.name, "id_instr",    id_instr,            e.idins);
            chk(e.name, "id_valid",    {31'd0, id_valid},   {31'd0, e.idv});
            chk(e.name, "bubble_cnt",  32'(bubble_cnt),     32'(e.cnt));
        end
    end

    // Apply one cycle of inputs and queue the expected outputs for that cycle.
    task automatic step(input string nm, input logic r, input logic s, input logic f,
                        input logic rv, input logic [31:0] rt, input logic [31:0] pc,
                        input logic [31:0] ins, input logic epcw, input logic [31:0] enpc,
                        input logic [31:0] eidpc, input logic [31:0] eidpc4,
                        input logic [31:0] eins, input logic ev, input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stall = s; flush = f; redirect_valid = rv;
        redirect_target = rt; pc_in = pc; instr_in = ins;
        e.name = nm; e.pcw = epcw; e.npc = enpc; e.idpc = eidpc; e.idpc4 = eidpc4;
        e.idins = eins; e.idv = ev; e.cnt = ecnt;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; pc_in = 32'h0; instr_in = 32'h0;

        //    name        rst s  f  rv target         pc_in          instr_in       pcw npc            id_pc          id_pc+4        id_instr       v  cnt
        step("rst0",     1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         1, 32'h0000_3000, 32'h0,         32'h0,         32'h0,         0, 0);
        step("rst1",     1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         1, 32'h0000_3000, 32'h0,         32'h0,         32'h0,         0, 0);
        step("line0",    0, 0, 0, 0, 32'h0,         32'h0000_3000, 32'h2008_0005, 1, 32'h0000_3004, 32'h0,         32'h0,         32'h0,         0, 0);
        step("stl_rd",   0, 1, 0, 1, 32'h0000_3043, 32'h0000_3004, 32'hAAAA_0001, 0, 32'h0000_3040, 32'h0000_3000, 32'h0000_3004, 32'h2008_0005, 1, 0);
        step("stl_hold", 0, 1, 0, 0, 32'h0,         32'h0000_3004, 32'hAAAA_0001, 0, 32'h0000_3040, 32'h0000_3000, 32'h0000_3004, 32'h2008_0005, 1, 0);
        step("release",  0, 0, 0, 0, 32'h0,         32'h0000_3004, 32'hAAAA_0001, 1, 32'h0000_3040, 32'h0000_3000, 32'h0000_3004, 32'h2008_0005, 1, 0);
        step("post_rd",  0, 0, 0, 0, 32'h0,         32'h0000_3040, 32'h1111_2222, 1, 32'h0000_3044, 32'h0,         32'h0,         32'h0,         0, 1);
        step("rd2_a",    0, 1, 0, 1, 32'h0000_3100, 32'h0000_3044, 32'h3333_4444, 0, 32'h0000_3100, 32'h0000_3040, 32'h0000_3044, 32'h1111_2222, 1, 1);
        step("rd2_b",    0, 1, 0, 1, 32'h0000_3200, 32'h0000_3044, 32'h3333_4444, 0, 32'h0000_3200, 32'h0000_3040, 32'h0000_3044, 32'h1111_2222, 1, 1);
        step("rd2_hold", 0, 1, 0, 0, 32'h0,         32'h0000_3044, 32'h3333_4444, 0, 32'h0000_3200, 32'h0000_3040, 32'h0000_3044, 32'h1111_2222, 1, 1);
        step("rd2_rel",  0, 0, 0, 0, 32'h0,         32'h0000_3044, 32'h3333_4444, 1, 32'h0000_3200, 32'h0000_3040, 32'h0000_3044, 32'h1111_2222, 1, 1);
        step("at3200",   0, 0, 0, 0, 32'h0,         32'h0000_3200, 32'h5555_6666, 1, 32'h0000_3204, 32'h0,         32'h0,         32'h0,         0, 2);
        step("fl_stl",   0, 1, 1, 0, 32'h0,         32'h0000_3204, 32'h7777_7777, 0, 32'h0000_3208, 32'h0000_3200, 32'h0000_3204, 32'h5555_6666, 1, 2);
        step("wrap",     0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h8888_9999, 1, 32'h0000_0000, 32'h0,         32'h0,         32'h0,         0, 3);
        step("fl_run",   0, 0, 1, 0, 32'h0,         32'h0000_0000, 32'h0,         1, 32'h0000_0004, 32'hFFFF_FFFC, 32'h0000_0000, 32'h8888_9999, 1, 3);
        step("rd3",      0, 1, 0, 1, 32'h0000_3300, 32'h0000_0000, 32'h0,         0, 32'h0000_3300, 32'h0,         32'h0,         32'h0,         0, 4);
        step("fl_pend",  0, 1, 1, 0, 32'h0,         32'h0000_0000, 32'h0,         0, 32'h0000_3300, 32'h0,         32'h0,         32'h0,         0, 4);
        step("rd3_rel",  0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0,         1, 32'h0000_3300, 32'h0,         32'h0,         32'h0,         0, 5);
        step("at3300",   0, 0, 0, 0, 32'h0,         32'h0000_3300, 32'hABCD_0000, 1, 32'h0000_3304, 32'h0,         32'h0,         32'h0,         0, 6);
        step("sat_a",    0, 0, 1, 0, 32'h0,         32'h0000_3304, 32'h0,         1, 32'h0000_3308, 32'h0000_3300, 32'h0000_3304, 32'hABCD_0000, 1, 6);
        step("sat_b",    0, 0, 1, 0, 32'h0,         32'h0000_3304, 32'h0,         1, 32'h0000_3308, 32'h0,         32'h0,         32'h0,         0, 7);
        step("sat_c",    0, 0, 1, 0, 32'h0,         32'h0000_3304, 32'h0,         1, 32'h0000_3308, 32'h0,         32'h0,         32'h0,         0, 7);
        step("rd_run",   0, 0, 0, 1, 32'h0000_3400, 32'h0000_3308, 32'h0,         1, 32'h0000_3400, 32'h0,         32'h0,         32'h0,         0, 7);
        step("rd_pend",  0, 1, 0, 1, 32'h0000_3501, 32'h0000_3400, 32'h0,         0, 32'h0000_3500, 32'h0,         32'h0,         32'h0,         0, 7);
        step("rst_mid",  1, 1, 0, 0, 32'h0,         32'h0000_3400, 32'h0,         1, 32'h0000_3000, 32'h0,         32'h0,         32'h0,         0, 7);
        step("post_rst", 0, 0, 0, 0, 32'h0,         32'h0000_3000, 32'hCAFE_0001, 1, 32'h0000_3004, 32'h0,         32'h0,         32'h0,         0, 0);
        step("final",    0, 0, 0, 0, 32'h0,         32'h0000_3004, 32'h0,         1, 32'h0000_3008, 32'h0000_3000, 32'h0000_3004, 32'hCAFE_0001, 1, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
